// File: rtl/udma_sc_fifo_lvl.sv
// Single-clock uDMA channel FIFO with arbitrary depth, occupancy level, programmable
// almost-full/almost-empty flags, synchronous flush and optional fall-through bypass.
module udma_sc_fifo_lvl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned FALL_THROUGH = 0,
    localparam int unsigned LVL_W       = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH-1:0] dst_data_o,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [LVL_W-1:0]      level_o,
    input  logic [LVL_W-1:0]      afull_thr_i,
    input  logic [LVL_W-1:0]      aempty_thr_i,
    output logic                  afull_o,
    output logic                  aempty_o
);

    localparam int unsigned PTR_W    = (BUFFER_DEPTH < 2) ? 1 : $clog2(BUFFER_DEPTH);
    localparam bit          FT_EN    = (FALL_THROUGH != 0);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUFFER_DEPTH);

    if (BUFFER_DEPTH < 2) begin : g_bad_depth
        $error("udma_sc_fifo_lvl: BUFFER_DEPTH must be >= 2");
    end

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;

    logic is_empty;
    logic is_full;
    logic bypass_valid;
    logic push;
    logic pop;
    logic pass_through;
    logic wr_en;
    logic rd_en;

    assign is_empty = (level == '0);
    assign is_full  = (level == FULL_LVL);

    // Ready is gated by reset so the source sees a refusal the instant reset asserts.
    assign src_ready_o  = ~rst_i & ~flush_i & ~is_full;
    assign bypass_valid = FT_EN & is_empty & src_valid_i;
    assign dst_valid_o  = ~rst_i & ~flush_i & (~is_empty | bypass_valid);
    assign dst_data_o   = (FT_EN && is_empty) ? src_data_i : mem[rd_ptr];

    assign push = src_valid_i & src_ready_o;
    assign pop  = dst_valid_o & dst_ready_i;

    // A bypassed word is consumed in the same cycle and never touches the storage.
    assign pass_through = bypass_valid & pop;
    assign wr_en        = push & ~pass_through;
    assign rd_en        = pop & ~pass_through;

    // NOTE: storage has no reset; contents are only observable once level marks them valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= src_data_i;
        end
    end

    // NOTE: non-blocking assignments keep every register update on the same edge ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign level_o  = level;
    assign afull_o  = (level >= afull_thr_i);
    assign aempty_o = (level <= aempty_thr_i);

endmodule

// File: tb/tb_udma_sc_fifo_lvl.sv
// Bench for udma_sc_fifo_lvl: a registered DEPTH=5 instance and a fall-through DEPTH=8
// instance, each compared every cycle against a queue-based reference model.
module tb_udma_sc_fifo_lvl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: BUFFER_DEPTH=5, FALL_THROUGH=0
    logic        a_rst = 1'b1, a_flush = 1'b0, a_sv = 1'b0, a_dr = 1'b0;
    logic [31:0] a_sd = '0;
    logic        a_sr, a_dv, a_af, a_ae;
    logic [31:0] a_dd;
    logic [2:0]  a_lvl;
    logic [2:0]  a_at = '0, a_et = '0;

    // Instance B: BUFFER_DEPTH=8, FALL_THROUGH=1
    logic        b_rst = 1'b1, b_flush = 1'b0, b_sv = 1'b0, b_dr = 1'b0;
    logic [31:0] b_sd = '0;
    logic        b_sr, b_dv, b_af, b_ae;
    logic [31:0] b_dd;
    logic [3:0]  b_lvl;
    logic [3:0]  b_at = '0, b_et = '0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    udma_sc_fifo_lvl #(.DATA_WIDTH(32), .BUFFER_DEPTH(5), .FALL_THROUGH(0)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush),
        .src_data_i(a_sd), .src_valid_i(a_sv), .src_ready_o(a_sr),
        .dst_data_o(a_dd), .dst_valid_o(a_dv), .dst_ready_i(a_dr),
        .level_o(a_lvl), .afull_thr_i(a_at), .aempty_thr_i(a_et),
        .afull_o(a_af), .aempty_o(a_ae)
    );

    udma_sc_fifo_lvl #(.DATA_WIDTH(32), .BUFFER_DEPTH(8), .FALL_THROUGH(1)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush),
        .src_data_i(b_sd), .src_valid_i(b_sv), .src_ready_o(b_sr),
        .dst_data_o(b_dd), .dst_valid_o(b_dv), .dst_ready_i(b_dr),
        .level_o(b_lvl), .afull_thr_i(b_at), .aempty_thr_i(b_et),
        .afull_o(b_af), .aempty_o(b_ae)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Outputs expected while reset is held: empty, nothing offered, flags from level 0.
    task automatic check_rst_a(input string tag);
        check({tag, "_ready"},  a_sr,  0);
        check({tag, "_valid"},  a_dv,  0);
        check({tag, "_level"},  a_lvl, 0);
        check({tag, "_afull"},  a_af,  (a_at == 0));
        check({tag, "_aempty"}, a_ae,  1);
    endtask

    task automatic check_rst_b(input string tag);
        check({tag, "_ready"},  b_sr,  0);
        check({tag, "_valid"},  b_dv,  0);
        check({tag, "_level"},  b_lvl, 0);
        check({tag, "_afull"},  b_af,  (b_at == 0));
        check({tag, "_aempty"}, b_ae,  1);
    endtask

    // One clock of instance A: drive, check at the falling edge, advance the model on the rising edge.
    task automatic cyc_a(input logic v, input logic [31:0] d, input logic r, input logic fl);
        int  n;
        bit  exp_ready, exp_valid, do_push, do_pop;
        a_sv = v; a_sd = d; a_dr = r; a_flush = fl;
        @(negedge clk);
        n         = qa.size();
        exp_ready = !fl && (n != 5);
        exp_valid = !fl && (n != 0);
        check("a_ready",  a_sr,  exp_ready);
        check("a_valid",  a_dv,  exp_valid);
        if (exp_valid) check("a_data", a_dd, qa[0]);
        check("a_level",  a_lvl, n);
        check("a_afull",  a_af,  (n >= int'(a_at)));
        check("a_aempty", a_ae,  (n <= int'(a_et)));
        do_push = v && exp_ready;
        do_pop  = exp_valid && r;
        @(posedge clk);
        #1;
        if (fl) qa.delete();
        else begin
            if (do_pop)  void'(qa.pop_front());
            if (do_push) qa.push_back(d);
        end
    endtask

    task automatic cyc_b(input logic v, input logic [31:0] d, input logic r, input logic fl);
        int  n;
        bit  exp_ready, exp_valid, do_push, do_pop;
        b_sv = v; b_sd = d; b_dr = r; b_flush = fl;
        @(negedge clk);
        n         = qb.size();
        exp_ready = !fl && (n != 8);
        exp_valid = !fl && ((n != 0) || v);
        check("b_ready",  b_sr,  exp_ready);
        check("b_valid",  b_dv,  exp_valid);
        if (exp_valid) check("b_data", b_dd, (n != 0) ? qb[0] : d);
        check("b_level",  b_lvl, n);
        check("b_afull",  b_af,  (n >= int'(b_at)));
        check("b_aempty", b_ae,  (n <= int'(b_et)));
        do_push = v && exp_ready;
        do_pop  = exp_valid && r;
        @(posedge clk);
        #1;
        if (fl) qb.delete();
        else if (n == 0 && do_push && do_pop) begin
            // word went straight through; nothing stored
        end else begin
            if (do_pop)  void'(qb.pop_front());
            if (do_push) qb.push_back(d);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        check_rst_a("a_reset");
        check_rst_b("b_reset");
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_at  = 3'd4;
        a_et  = 3'd1;

        // ---------------- A: fill 0xA0..0xA4, full refusal ----------------
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 32'hA0 + i, 1'b0, 1'b0);
        cyc_a(1'b1, 32'hBAD, 1'b0, 1'b0);
        // full with simultaneous valid and ready: only the pop happens
        cyc_a(1'b1, 32'hEE, 1'b1, 1'b0);
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc_a(1'b0, 32'h0, 1'b1, 1'b0);
        // pointers have wrapped; three more in order
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 32'h0, 1'b1, 1'b0);

        // ---------------- A: flush at level 3 dominates handshake ----------------
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 32'hD0 + i, 1'b0, 1'b0);
        cyc_a(1'b1, 32'h77, 1'b1, 1'b1);
        cyc_a(1'b1, 32'h11, 1'b0, 1'b0);
        cyc_a(1'b0, 32'h0, 1'b1, 1'b0);
        cyc_a(1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- A: randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                a_at = 3'($urandom_range(0, 7));
                a_et = 3'($urandom_range(0, 7));
            end
            cyc_a(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 31) == 0));
        end

        // ---------------- B: fall-through ----------------
        b_rst = 1'b0;
        b_at  = 4'd4;
        b_et  = 4'd1;
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0);
        cyc_b(1'b1, 32'h55, 1'b1, 1'b0);   // passes through, level stays 0
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0);
        cyc_b(1'b1, 32'h55, 1'b0, 1'b0);   // offered but not taken: stored
        cyc_b(1'b1, 32'h66, 1'b0, 1'b0);   // head still 0x55 while non-empty
        cyc_b(1'b0, 32'h0, 1'b1, 1'b0);
        cyc_b(1'b0, 32'h0, 1'b1, 1'b0);
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- B: flag sweep 0..8 with afull=4 aempty=1 ----------------
        for (int i = 0; i < 8; i++) cyc_b(1'b1, 32'h100 + i, 1'b0, 1'b0);
        cyc_b(1'b1, 32'hBAD, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc_b(1'b0, 32'h0, 1'b1, 1'b0);
        cyc_b(1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- B: async reset mid-burst at level 6 ----------------
        for (int i = 0; i < 6; i++) cyc_b(1'b1, 32'h200 + i, 1'b0, 1'b0);
        b_sv = 1'b1; b_sd = 32'h2FF; b_dr = 1'b1;
        #2;
        b_rst = 1'b1;
        #1;
        check_rst_b("b_midrst");
        qb.delete();
        @(posedge clk); #1;
        b_rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc_b(1'b1, 32'h300 + i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc_b(1'b0, 32'h0, 1'b1, 1'b0);

        // ---------------- B: randomized traffic, thresholds may exceed depth ----------------
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                b_at = 4'($urandom_range(0, 15));
                b_et = 4'($urandom_range(0, 15));
            end
            cyc_b(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
